// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for the shared main-memory port.
// Holds each access for MEM_LAT cycles, then acks the winning requester.
//
// Ports:
//   clk, rst_b          clock, async active-low reset
//   i_req/i_addr/i_ack  fetch read requester
//   d_req/d_we/d_addr/d_wdata/d_ack  data-side requester
//   rdata               last word read from memory (big-endian bytes)
//   mem_addr, mem_data_in, mem_write_en, mem_data_out  memory port
//   busy, owner         transaction in flight; last granted side (1 = data)
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data_in [0:3],
    output logic        mem_write_en,
    input  logic [7:0]  mem_data_out [0:3],
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic        owner_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        grant;
    logic        grant_sel;
    logic        last_busy;

    assign last_busy = (state_q == BUSY) && (cnt_q == 4'd0);

    // owner_q doubles as last_owner: on a tie the other side wins.
    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        grant_sel = owner_q;
        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    grant     = 1'b1;
                    grant_sel = ~owner_q;
                end else if (d_req) begin
                    grant     = 1'b1;
                    grant_sel = 1'b1;
                end else if (i_req) begin
                    grant     = 1'b1;
                    grant_sel = 1'b0;
                end
                if (grant) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            owner_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                addr_q  <= grant_sel ? d_addr : i_addr;
                we_q    <= grant_sel & d_we;
                // Reads present zero on the write bus.
                wdata_q <= (grant_sel && d_we) ? d_wdata : 32'h0;
                owner_q <= grant_sel;
                cnt_q   <= CNT_INIT;
            end else if (state_q == BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (last_busy && !we_q) begin
                rdata_q <= {mem_data_out[0], mem_data_out[1],
                            mem_data_out[2], mem_data_out[3]};
            end
        end
    end

    // Decoded from state so reset drops the strobe immediately.
    assign mem_write_en   = last_busy & we_q;
    assign i_ack          = (state_q == RESP) & ~owner_q;
    assign d_ack          = (state_q == RESP) & owner_q;
    assign busy           = (state_q != IDLE);
    assign owner          = owner_q;
    assign mem_addr       = addr_q;
    assign rdata          = rdata_q;
    assign mem_data_in[0] = wdata_q[31:24];
    assign mem_data_in[1] = wdata_q[23:16];
    assign mem_data_in[2] = wdata_q[15:8];
    assign mem_data_in[3] = wdata_q[7:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=4 and a MEM_LAT=1 instance,
// directed requests with queued expectations checked by per-instance monitors.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        side;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0040: rom = 32'h8C01_0004;
            32'h0000_0008: rom = 32'hCAFE_F00D;
            32'h0000_0200: rom = 32'h1234_5678;
            32'h0000_0300: rom = 32'hA5A5_A5A5;
            default:       rom = 32'h0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_h
        localparam int LAT = (g == 0) ? 4 : 1;

        logic        rst_b;
        logic        i_req;
        logic [31:0] i_addr;
        logic        i_ack;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        d_ack;
        logic [31:0] rdata;
        logic [31:0] mem_addr;
        logic [7:0]  mem_data_in [0:3];
        logic        mem_write_en;
        logic [7:0]  mem_data_out [0:3];
        logic        busy;
        logic        owner;
        logic [31:0] din;
        logic [31:0] word;
        logic        no_sb;
        logic        ack_due;
        exp_t        q[$];
        wr_t         wq[$];

        mem_port_arbiter #(.MEM_LAT(LAT)) u_dut (
            .clk         (clk),
            .rst_b       (rst_b),
            .i_req       (i_req),
            .i_addr      (i_addr),
            .i_ack       (i_ack),
            .d_req       (d_req),
            .d_we        (d_we),
            .d_addr      (d_addr),
            .d_wdata     (d_wdata),
            .d_ack       (d_ack),
            .rdata       (rdata),
            .mem_addr    (mem_addr),
            .mem_data_in (mem_data_in),
            .mem_write_en(mem_write_en),
            .mem_data_out(mem_data_out),
            .busy        (busy),
            .owner       (owner)
        );

        assign din = {mem_data_in[0], mem_data_in[1],
                      mem_data_in[2], mem_data_in[3]};

        always_comb begin
            word = rom(mem_addr);
            mem_data_out[0] = word[31:24];
            mem_data_out[1] = word[23:16];
            mem_data_out[2] = word[15:8];
            mem_data_out[3] = word[7:0];
        end

        function automatic string nm(input string s);
            return $sformatf("L%0d %s", LAT, s);
        endfunction

        always @(negedge clk) begin
            if (!rst_b) begin
                ack_due <= 1'b0;
            end else begin
                ack_due <= mem_write_en;
                if (ack_due)
                    chk(nm("ack after write strobe"), 32'(d_ack), 32'd1);
                if (mem_write_en) begin
                    if (wq.size() == 0) begin
                        bad(nm("unexpected mem_write_en"));
                    end else begin
                        chk(nm("write addr"), mem_addr, wq[0].addr);
                        chk(nm("write data"), din, wq[0].data);
                        void'(wq.pop_front());
                    end
                end
                if (i_ack || d_ack) begin
                    if (q.size() == 0) begin
                        bad(nm("unexpected ack"));
                    end else begin
                        chk(nm("ack side {i,d}"), {30'h0, i_ack, d_ack},
                            q[0].side ? 32'd1 : 32'd2);
                        chk(nm("resp addr"), mem_addr, q[0].addr);
                        chk(nm("rdata"), rdata, q[0].rdata);
                        void'(q.pop_front());
                    end
                end else if (busy && !no_sb) begin
                    if (q.size() == 0) begin
                        bad(nm("busy without request"));
                    end else begin
                        chk(nm("busy addr"), mem_addr, q[0].addr);
                        chk(nm("busy wdata"), din,
                            q[0].we ? q[0].wdata : 32'h0);
                        chk(nm("busy owner"), 32'(owner), 32'(q[0].side));
                    end
                end
            end
        end

        task automatic init();
            rst_b   = 1'b0;
            i_req   = 1'b0;
            i_addr  = 32'h0;
            d_req   = 1'b0;
            d_we    = 1'b0;
            d_addr  = 32'h0;
            d_wdata = 32'h0;
            no_sb   = 1'b0;
        endtask

        task automatic do_reset();
            rst_b = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_b = 1'b1;
        endtask

        task automatic chk_reset();
            #1;
            chk(nm("reset acks"), {30'h0, i_ack, d_ack}, 32'h0);
            chk(nm("reset busy/owner/we"),
                {29'h0, busy, owner, mem_write_en}, 32'h0);
            chk(nm("reset mem_addr"), mem_addr, 32'h0);
            chk(nm("reset rdata"), rdata, 32'h0);
            chk(nm("reset mem_data_in"), din, 32'h0);
        endtask

        task automatic expect_rd(input logic s, input logic [31:0] a,
                                 input logic [31:0] r);
            q.push_back('{side: s, we: 1'b0, addr: a, wdata: 32'h0,
                          rdata: r});
        endtask

        task automatic expect_wr(input logic [31:0] a, input logic [31:0] w,
                                 input logic [31:0] keep);
            q.push_back('{side: 1'b1, we: 1'b1, addr: a, wdata: w,
                          rdata: keep});
            wq.push_back('{addr: a, data: w});
        endtask

        // Hold a request for n acks; lat/gap of 0 skip the timing checks.
        task automatic xact(input logic s, input logic we,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int n, input int lat, input int gap,
                            output int first);
            int cyc;
            int last;
            int got;
            cyc   = 0;
            last  = 0;
            got   = 0;
            first = 0;
            @(posedge clk);
            #1;
            if (s) begin
                d_req   = 1'b1;
                d_we    = we;
                d_addr  = a;
                d_wdata = wd;
            end else begin
                i_req  = 1'b1;
                i_addr = a;
            end
            while (got < n && cyc < 400) begin
                @(negedge clk);
                cyc++;
                if (s ? d_ack : i_ack) begin
                    if (got == 0) begin
                        first = cyc;
                        if (lat > 0)
                            chk(nm("ack latency"), 32'(cyc - 1), 32'(lat));
                    end else if (gap > 0) begin
                        chk(nm("ack spacing"), 32'(cyc - last), 32'(gap));
                    end
                    last = cyc;
                    got++;
                end
            end
            if (got < n)
                bad(nm("ack timeout"));
            @(posedge clk);
            #1;
            if (s) begin
                d_req = 1'b0;
                d_we  = 1'b0;
            end else begin
                i_req = 1'b0;
            end
        endtask

        // Write aborted by reset in its second BUSY cycle.
        task automatic abort_write();
            no_sb = 1'b1;
            @(posedge clk);
            #1;
            d_req   = 1'b1;
            d_we    = 1'b1;
            d_addr  = 32'h104;
            d_wdata = 32'h55AA_55AA;
            @(posedge clk);
            @(posedge clk);
            #1;
            chk(nm("busy before abort"), 32'(busy), 32'd1);
            #1;
            rst_b = 1'b0;
            #1;
            chk(nm("abort busy"), 32'(busy), 32'd0);
            chk(nm("abort write_en"), 32'(mem_write_en), 32'd0);
            chk(nm("abort mem_addr"), mem_addr, 32'h0);
            d_req = 1'b0;
            d_we  = 1'b0;
            @(negedge clk);
            rst_b = 1'b1;
            repeat (6) @(negedge clk);
            chk(nm("idle after abort"), 32'(busy), 32'd0);
            no_sb = 1'b0;
        endtask
    end

    task automatic seq_l4();
        int f0;
        int f1;
        g_h[0].do_reset();
        g_h[0].chk_reset();
        // Ties from reset: data first, then fetch, every round.
        g_h[0].expect_rd(1'b1, 32'h200, 32'h1234_5678);
        g_h[0].expect_rd(1'b0, 32'h40, 32'h8C01_0004);
        fork
            g_h[0].xact(1'b1, 1'b0, 32'h200, 32'h0, 1, 5, 0, f0);
            g_h[0].xact(1'b0, 1'b0, 32'h40, 32'h0, 1, 0, 0, f1);
        join
        g_h[0].expect_rd(1'b1, 32'h300, 32'hA5A5_A5A5);
        g_h[0].expect_rd(1'b0, 32'h40, 32'h8C01_0004);
        fork
            g_h[0].xact(1'b1, 1'b0, 32'h300, 32'h0, 1, 5, 0, f0);
            g_h[0].xact(1'b0, 1'b0, 32'h40, 32'h0, 1, 0, 0, f1);
        join
        g_h[0].expect_rd(1'b1, 32'h200, 32'h1234_5678);
        g_h[0].expect_rd(1'b0, 32'h8, 32'hCAFE_F00D);
        fork
            g_h[0].xact(1'b1, 1'b0, 32'h200, 32'h0, 1, 5, 0, f0);
            g_h[0].xact(1'b0, 1'b0, 32'h8, 32'h0, 1, 0, 0, f1);
        join
        g_h[0].expect_rd(1'b0, 32'h40, 32'h8C01_0004);
        g_h[0].xact(1'b0, 1'b0, 32'h40, 32'h0, 1, 5, 0, f0);
        g_h[0].expect_wr(32'h100, 32'hDEAD_BEEF, 32'h8C01_0004);
        g_h[0].xact(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1, 5, 0, f0);
        // Data held continuously; fetch raised mid-transaction.
        g_h[0].expect_rd(1'b1, 32'h300, 32'hA5A5_A5A5);
        g_h[0].expect_rd(1'b0, 32'h40, 32'h8C01_0004);
        g_h[0].expect_rd(1'b1, 32'h300, 32'hA5A5_A5A5);
        fork
            g_h[0].xact(1'b1, 1'b0, 32'h300, 32'h0, 2, 5, 0, f0);
            begin
                repeat (2) @(posedge clk);
                g_h[0].xact(1'b0, 1'b0, 32'h40, 32'h0, 1, 0, 0, f1);
            end
        join
        chk("L4 fetch served within 12 cycles", 32'(f1 <= 12), 32'd1);
        g_h[0].abort_write();
        g_h[0].expect_rd(1'b0, 32'h200, 32'h1234_5678);
        g_h[0].xact(1'b0, 1'b0, 32'h200, 32'h0, 1, 5, 0, f0);
        repeat (3) @(posedge clk);
    endtask

    task automatic seq_l1();
        int f0;
        g_h[1].do_reset();
        g_h[1].chk_reset();
        g_h[1].expect_rd(1'b1, 32'h8, 32'hCAFE_F00D);
        g_h[1].xact(1'b1, 1'b0, 32'h8, 32'h0, 1, 2, 0, f0);
        g_h[1].expect_wr(32'h10, 32'h1111_2222, 32'hCAFE_F00D);
        g_h[1].xact(1'b1, 1'b1, 32'h10, 32'h1111_2222, 1, 2, 0, f0);
        g_h[1].expect_rd(1'b0, 32'h40, 32'h8C01_0004);
        g_h[1].expect_rd(1'b0, 32'h40, 32'h8C01_0004);
        g_h[1].expect_rd(1'b0, 32'h40, 32'h8C01_0004);
        g_h[1].xact(1'b0, 1'b0, 32'h40, 32'h0, 3, 2, 3, f0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        g_h[0].init();
        g_h[1].init();
        fork
            seq_l4();
            seq_l1();
        join
        chk("L4 acks outstanding", 32'(g_h[0].q.size()), 32'd0);
        chk("L4 writes outstanding", 32'(g_h[0].wq.size()), 32'd0);
        chk("L1 acks outstanding", 32'(g_h[1].q.size()), 32'd0);
        chk("L1 writes outstanding", 32'(g_h[1].wq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
